// File: rtl/axis_atomic_fanout_pkg.sv
// Shared helpers for the axis fan-out blocks: width helper, lane packing and
// drop-counter constants.
package axis_atomic_fanout_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

  // Number of bits needed to encode values 0..value-1 (minimum 1).
  function automatic int fo_clog2(input int value);
    int r;
    r = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) < value) r = b + 1;
    end
    return r;
  endfunction

  // Low bit of a channel lane in a packed multi-channel bus.
  function automatic int fo_lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/axis_fo_chbuf.sv
// Single-channel FIFO buffer: registered occupancy and pointers, storage
// left unreset, data presented from the head slot one cycle after the write.
module axis_fo_chbuf
  import axis_atomic_fanout_pkg::*;
#(
  parameter int CH_BITS = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [CH_BITS-1:0] i_data,
  output logic               o_full,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [CH_BITS-1:0] o_data
);

  localparam int PTR_W = fo_clog2(DEPTH);
  localparam int CNT_W = fo_clog2(DEPTH + 1);

  logic [CH_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop;

  assign w_pop   = o_valid & i_ready;
  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_data  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/axis_atomic_fanout.sv
// Atomic fan-out: one combined beat is written into every selected channel
// buffer on the same edge, or not at all; channels then drain independently.
module axis_atomic_fanout
  import axis_atomic_fanout_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int CH_BITS = 8,
  parameter int DEPTH   = 4
) (
  input  logic                   s_ul_clk,
  input  logic                   reset_n,
  output logic                   s_axis_comb_tready,
  input  logic                   s_axis_comb_tvalid,
  input  logic [NCH*CH_BITS-1:0] s_axis_comb_tdata,
  input  logic [NCH-1:0]         s_axis_comb_tuser,
  input  logic [NCH-1:0]         m_axis_tready,
  output logic [NCH-1:0]         m_axis_tvalid,
  output logic [NCH*CH_BITS-1:0] m_axis_tdata,
  output logic [15:0]            stat_drop_cnt
);

  logic [NCH-1:0]        w_full;
  logic                  w_accept;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Ready looks only at registered fullness, so a same-cycle pop never bypasses.
  assign s_axis_comb_tready = reset_n & ~(|w_full);
  assign w_accept           = s_axis_comb_tvalid & s_axis_comb_tready;
  assign stat_drop_cnt      = r_drop_cnt;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      axis_fo_chbuf #(
        .CH_BITS(CH_BITS),
        .DEPTH  (DEPTH)
      ) u_chbuf (
        .clk    (s_ul_clk),
        .rst_n  (reset_n),
        .i_push (w_accept & s_axis_comb_tuser[gi]),
        .i_data (s_axis_comb_tdata[fo_lane_lo(gi, CH_BITS) +: CH_BITS]),
        .o_full (w_full[gi]),
        .o_valid(m_axis_tvalid[gi]),
        .i_ready(m_axis_tready[gi]),
        .o_data (m_axis_tdata[fo_lane_lo(gi, CH_BITS) +: CH_BITS])
      );
    end
  endgenerate

  always_ff @(posedge s_ul_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_accept && (s_axis_comb_tuser == '0) && (r_drop_cnt != DROP_CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

endmodule
